stage_shift_ctrl: RTL and testbench
===================================

Name: stage_shift_ctrl

Overview:
Upstream controller for the six-stage stage clock. On a request, it emits one start pulse and then a fixed count of evenly spaced single-cycle shift strobes, which the downstream stage clock consumes to advance its stage pattern. It also tracks the current stage index, reports busy, and signals done once the last stage interval has elapsed. The controller supports a synchronous abort.

Parameters:
NUM_STAGES, 6, number of shift strobes issued per run (>=2).
DIV_W, 8, width of the strobe-spacing field.
IDX_W, $clog2(NUM_STAGES), width of stage_idx (3 at default).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
req  input  1  run request; level-sampled, only acted on in IDLE.
div  input  DIV_W  strobe spacing minus one; latched at request accept.
abort  input  1  synchronous cancel of an active run.
start  output  1  one-cycle pulse at first strobe of a run.
shift  output  1  one-cycle stage-advance strobe.
stage_idx  output  IDX_W  index of most recent shift in the run; 0 in IDLE.
busy  output  1  high from the first strobe through the done cycle.
done  output  1  one-cycle pulse at the end of a completed run.

Behaviour:
- Reset (rst=0, async): state IDLE; start, shift, busy, done all 0; stage_idx, interval counter and div_q all 0. Outputs clear immediately, with no clock required. After release, the first action occurs no earlier than the first edge with req=1.
- All outputs are registered; no combinational path exists from any input to any output.
- FSM states:
  - IDLE -> RUN when req=1 at an edge (cycle 0). div is latched into div_q at that edge.
  - RUN -> DONE after the NUM_STAGES-th interval expires.
  - DONE -> IDLE unconditionally, one cycle later.
  - RUN -> IDLE on abort.
- Strobe timing, relative to req sampled at cycle 0:
  - Cycle 1: start=1, shift=1, stage_idx=0, busy=1.
  - Shift k (k=0..NUM_STAGES-1) occurs at cycle 1+k*(div_q+1); stage_idx=k from that cycle onward.
  - shift is 0 on all other cycles; start is high only at k=0.
  - done=1 for exactly one cycle, at cycle 1+NUM_STAGES*(div_q+1) (DONE state); busy is still 1 and shift is 0 in that cycle.
  - The following cycle: busy=0, stage_idx=0.
- div_q=0 gives back-to-back strobes, one every cycle.
- div_q is max (2^DIV_W-1): spacing is 2^DIV_W cycles. The interval counter is DIV_W bits, counts down from div_q, and does not overflow.
- Changing div while busy has no effect on the current run.
- req while busy (RUN or DONE) is ignored and is not queued. A req held high continuously starts a new run from the IDLE cycle after DONE, so runs are separated by exactly one idle cycle.
- abort=1 in RUN: at the next edge the state becomes IDLE and all outputs clear. No done pulse is issued. A shift scheduled for that same edge is suppressed.
- abort in IDLE or DONE is ignored. abort has priority over interval expiry.
- abort and req both high in IDLE: req wins, and the run starts.
- Reset asserted mid-run: immediate return to IDLE state and values. No partial done.

Test Plan:
1. Reset 0->1, req=1 at cycle 0, div=0 -> start and shift at cycle 1; shift at cycles 1-6 with stage_idx 0..5; done at cycle 7; busy high in cycles 1-7, 0 at cycle 8.
2. div=3, single req pulse -> shifts at cycles 1, 5, 9, 13, 17, 21; done at 25; shift low on all other cycles; start only at cycle 1.
3. div=3, req held high throughout, div changed to 0 at cycle 4 -> first run timing unchanged (done at 25); second run start at cycle 27 using div=0.
4. div=3, abort=1 at cycle 8 -> shift at 1 and 5 only; busy=0 and stage_idx=0 at cycle 9; no done ever; no shift at 9.
5. div=255 -> shifts spaced 256 cycles (at cycles 1, 257, ...); done at cycle 1537.
6. div=1, rst driven low mid-cycle at cycle 6 -> all outputs 0 before the next edge; after release, no activity until a new req.

Source files
------------

// File: rtl/stage_shift_ctrl.sv
// Upstream controller for the six-stage stage clock: one start pulse, then
// NUM_STAGES evenly spaced shift strobes, a done pulse, and synchronous abort.
module stage_shift_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int DIV_W      = 8,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             start,
  output logic             shift,
  output logic [IDX_W-1:0] stage_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W:0] LAST_COUNT = (IDX_W + 1)'(NUM_STAGES);

  logic [1:0]       state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  // Number of strobes already issued in this run; one bit wider than stage_idx.
  logic [IDX_W:0]   nshift;

  // The accepting edge issues the first strobe directly, so cnt then counts
  // down the spacing before each following strobe and before done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      div_q     <= '0;
      cnt       <= '0;
      nshift    <= '0;
      start     <= 1'b0;
      shift     <= 1'b0;
      stage_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start <= 1'b0;
      shift <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state     <= S_RUN;
            div_q     <= div;
            cnt       <= div;
            nshift    <= (IDX_W + 1)'(1);
            start     <= 1'b1;
            shift     <= 1'b1;
            stage_idx <= '0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort beats interval expiry: any strobe due at this edge is dropped.
            state     <= S_IDLE;
            cnt       <= '0;
            nshift    <= '0;
            stage_idx <= '0;
            busy      <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (nshift == LAST_COUNT) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            shift     <= 1'b1;
            stage_idx <= nshift[IDX_W-1:0];
            nshift    <= nshift + 1'b1;
            cnt       <= div_q;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          nshift    <= '0;
          stage_idx <= '0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          nshift    <= '0;
          stage_idx <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_shift_ctrl.sv
// Bench for stage_shift_ctrl: per-cycle expected outputs derived from the
// strobe timing formulas are queued when inputs are driven, then compared.
module tb_stage_shift_ctrl;

  localparam int NUM   = 6;
  localparam int DIV_W = 8;
  localparam int IDX_W = 3;
  localparam int W     = 4 + IDX_W;

  logic             clk;
  logic             rst;
  logic             req;
  logic [DIV_W-1:0] div;
  logic             abort;
  logic             start;
  logic             shift;
  logic [IDX_W-1:0] stage_idx;
  logic             busy;
  logic             done;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  stage_shift_ctrl #(.NUM_STAGES(NUM), .DIV_W(DIV_W), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .div(div),
    .abort(abort),
    .start(start),
    .shift(shift),
    .stage_idx(stage_idx),
    .busy(busy),
    .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [W-1:0] out_vec = {start, shift, done, busy, stage_idx};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {start,shift,done,busy,stage_idx} in cycle c of a run whose req
  // was sampled at the end of cycle 0; a >= 0 means abort was high in cycle a.
  function automatic logic [W-1:0] exp_at(input int c, input int d, input int a);
    int done_c;
    int k;
    logic st;
    logic sh;
    done_c = 1 + NUM * (d + 1);
    if (c < 1 || c > done_c || (a >= 0 && c > a)) return '0;
    if (c == done_c) return {1'b0, 1'b0, 1'b1, 1'b1, IDX_W'(NUM - 1)};
    k  = (c - 1) / (d + 1);
    sh = ((c - 1) % (d + 1)) == 0;
    st = sh && (k == 0);
    return {st, sh, 1'b0, 1'b1, IDX_W'(k)};
  endfunction

  // driver: one cycle of inputs, expectation for the following cycle
  task automatic cyc(input logic r, input logic [DIV_W-1:0] dv, input logic ab,
                     input logic [W-1:0] e, input string tag);
    exp_q.push_back(e);
    req   = r;
    div   = dv;
    abort = ab;
    @(posedge clk);
    #1;
    check(tag, 32'(out_vec), 32'(exp_q.pop_front()));
  endtask

  // One run with div d; abort in cycle a (-1 none); ab0 raises abort with req;
  // mid_req re-raises req in a busy cycle; div is scrambled after cycle 0.
  task automatic do_run(input int d, input int a, input bit ab0, input int mid_req,
                        input string tag);
    int done_c;
    logic r;
    logic ab;
    logic [DIV_W-1:0] dv;
    done_c = 1 + NUM * (d + 1);
    for (int c = 0; c <= done_c; c++) begin
      r  = (c == 0) || (c == mid_req);
      ab = (c == 0) ? ab0 : (c == a);
      dv = (c == 0) ? DIV_W'(d) : DIV_W'($urandom_range(0, 255));
      cyc(r, dv, ab, exp_at(c + 1, d, a), tag);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req   = 1'b0;
    div   = '0;
    abort = 1'b0;
    #2;
    check("reset_async", 32'(out_vec), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd5, 1'b0, '0, "idle_after_reset");
    cyc(1'b0, 8'd2, 1'b1, '0, "abort_in_idle");

    do_run(0, -1, 1'b0, -1, "div0_run");
    do_run(3, -1, 1'b0, 10, "div3_req_busy");
    do_run(2, -1, 1'b0, 1 + NUM * 3, "req_in_done");

    // req held high, div dropped to 0 mid-run; next run starts after one idle cycle
    for (int c = 0; c <= 25; c++)
      cyc(1'b1, (c < 4) ? 8'd3 : 8'd0, 1'b0, exp_at(c + 1, 3, -1), "held_run1");
    for (int c = 26; c <= 34; c++)
      cyc(c < 34, 8'd0, 1'b0, exp_at(c + 1 - 26, 0, -1), "held_run2");

    do_run(3, 8, 1'b0, -1, "abort_c8");
    do_run(1, 4, 1'b1, -1, "req_beats_abort");
    do_run(1, 1 + NUM * 2, 1'b0, -1, "abort_in_done");
    do_run(255, -1, 1'b0, -1, "div255");

    for (int i = 0; i < 4; i++) begin
      int d;
      int a;
      d = $urandom_range(0, 5);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, NUM * (d + 1)) : -1;
      do_run(d, a, 1'b0, -1, "random_run");
    end

    // reset asserted between edges while a div=1 run is in progress
    for (int c = 0; c <= 5; c++)
      cyc(c == 0, 8'd1, 1'b0, exp_at(c + 1, 1, -1), "pre_reset_run");
    #2;
    rst = 1'b0;
    #1;
    check("rst_midrun", 32'(out_vec), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_held", 32'(out_vec), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd1, 1'b0, '0, "idle_after_rst");
    do_run(0, -1, 1'b0, -1, "run_after_rst");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
